// File: rtl/pio_poll_pkg.sv
// Shared types and constants for the PIO poll scheduler: FSM states, slave register map,
// CTRL bit positions and debounce counter width.
package pio_poll_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSel,
    StCap,
    StUpd
  } state_e;

  localparam logic [1:0] AddrState = 2'd0;
  localparam logic [1:0] AddrEdge  = 2'd1;
  localparam logic [1:0] AddrMask  = 2'd2;
  localparam logic [1:0] AddrCtrl  = 2'd3;

  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlForceBit = 1;
  localparam int unsigned CtrlBusyBit  = 2;

  // Stable-sample counter width, enough for a DEB_CNT of up to 15.
  localparam int unsigned CntW = 4;

endpackage

// File: rtl/pio_poll_debounce.sv
// Per-port debounce: captures one raw sample per round, counts consecutive identical samples
// and commits the sample to the debounced state once it has been stable for DEB_CNT rounds.
module pio_poll_debounce
  import pio_poll_pkg::*;
#(
  parameter int unsigned PORT_W  = 4,
  parameter int unsigned DEB_CNT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cap_i,
  input  logic [PORT_W-1:0] data_i,
  input  logic              upd_i,
  output logic [PORT_W-1:0] state_o,
  output logic [PORT_W-1:0] edge_o
);

  localparam logic [CntW-1:0] DebMax = CntW'(DEB_CNT);

  logic [PORT_W-1:0] samp_q, samp_d;
  logic [PORT_W-1:0] prev_q, prev_d;
  logic [PORT_W-1:0] state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_comb begin
    samp_d  = cap_i ? data_i : samp_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    edge_o  = '0;
    if (upd_i) begin
      prev_d = samp_q;
      if (samp_q == prev_q) begin
        cnt_d = (cnt_q >= DebMax) ? DebMax : cnt_q + 1'b1;
      end else begin
        cnt_d = CntW'(1);
      end
      // Acceptance uses the count including this round's sample.
      if ((cnt_d >= DebMax) && (samp_q != state_q)) begin
        state_d = samp_q;
        edge_o  = samp_q ^ state_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samp_q  <= '0;
      prev_q  <= '0;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      samp_q  <= samp_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/pio_poll_scheduler.sv
// Polls NUM_PORTS PIO slaves round-robin, debounces their inputs and exposes STATE/EDGE/MASK/CTRL.
// Optional feature: define PIO_POLL_IRQ_EN for a working MASK register and level interrupt.
module pio_poll_scheduler
  import pio_poll_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PORT_W    = 4,
  parameter int unsigned POLL_DIV  = 50000,
  parameter int unsigned DEB_CNT   = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic [NUM_PORTS-1:0]    m_chipselect,
  output logic [1:0]              m_address,
  input  logic [32*NUM_PORTS-1:0] m_readdata,
  input  logic [1:0]              s_address,
  input  logic                    s_read,
  input  logic                    s_write,
  input  logic [31:0]             s_writedata,
  output logic [31:0]             s_readdata,
  output logic                    irq
);

  localparam int unsigned StW  = NUM_PORTS * PORT_W;
  localparam int unsigned DivW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_PORTS - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(POLL_DIV - 1);

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [DivW-1:0]    div_q, div_d;
  logic               en_q, pend_q, pend_d;
  logic [StW-1:0]     edge_q, edge_d, edge_set, state_all, mask_val;
  logic [31:0]        rdata_q, rdata_mux;
  logic [NUM_PORTS-1:0] cap_en;
  logic               upd, tick, busy, wr_ctrl, wr_edge, force_req;
  logic               unused_bits;

  assign unused_bits = ^{s_writedata, m_readdata};
  assign m_address   = 2'b00;
  assign busy        = (state_q != StIdle);
  assign wr_ctrl     = s_write && (s_address == AddrCtrl);
  assign wr_edge     = s_write && (s_address == AddrEdge);
  assign force_req   = wr_ctrl && s_writedata[CtrlForceBit];

  always_comb begin
    div_d = '0;
    tick  = 1'b0;
    if (en_q) begin
      if (div_q == DivLast) begin
        tick = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Requests seen while a round is running collapse into one follow-up round.
  assign pend_d = busy ? (pend_q | tick | force_req) : 1'b0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (tick || force_req || pend_q) begin
          state_d = StSel;
          idx_d   = '0;
        end
      end
      StSel: state_d = StCap;
      StCap: begin
        if (idx_q == IdxLast) begin
          state_d = StUpd;
        end else begin
          state_d = StSel;
          idx_d   = idx_q + 1'b1;
        end
      end
      StUpd: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_chipselect = '0;
    cap_en       = '0;
    upd          = 1'b0;
    unique case (state_q)
      StSel:   m_chipselect = NUM_PORTS'(1) << idx_q;
      StCap:   cap_en = NUM_PORTS'(1) << idx_q;
      StUpd:   upd = 1'b1;
      default: ;
    endcase
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    pio_poll_debounce #(
      .PORT_W  (PORT_W),
      .DEB_CNT (DEB_CNT)
    ) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .cap_i   (cap_en[p]),
      .data_i  (m_readdata[32*p +: PORT_W]),
      .upd_i   (upd),
      .state_o (state_all[p*PORT_W +: PORT_W]),
      .edge_o  (edge_set[p*PORT_W +: PORT_W])
    );
  end

  // New edges win over a simultaneous write-one-to-clear.
  assign edge_d = (edge_q & ~(wr_edge ? s_writedata[StW-1:0] : '0)) | edge_set;

  always_comb begin
    rdata_mux = '0;
    unique case (s_address)
      AddrState: rdata_mux[StW-1:0] = state_all;
      AddrEdge:  rdata_mux[StW-1:0] = edge_q;
      AddrMask:  rdata_mux[StW-1:0] = mask_val;
      AddrCtrl: begin
        rdata_mux[CtrlEnBit]   = en_q;
        rdata_mux[CtrlBusyBit] = busy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      edge_q  <= '0;
      rdata_q <= '0;
    end else begin
      div_q  <= div_d;
      pend_q <= pend_d;
      edge_q <= edge_d;
      if (wr_ctrl) begin
        en_q <= s_writedata[CtrlEnBit];
      end
      if (s_read) begin
        rdata_q <= rdata_mux;
      end
    end
  end

  assign s_readdata = rdata_q;

`ifdef PIO_POLL_IRQ_EN
  logic [StW-1:0] mask_q;
  logic           irq_q;
  logic           wr_mask;

  assign wr_mask = s_write && (s_address == AddrMask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_mask) begin
        mask_q <= s_writedata[StW-1:0];
      end
      irq_q <= |(edge_q & mask_q);
    end
  end

  assign mask_val = mask_q;
  assign irq      = irq_q;
`else
  assign mask_val = '0;
  assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_pio_poll_scheduler.sv
// Scoreboard bench for pio_poll_scheduler: expected read data, chipselects and probes are queued
// by the stimulus and checked by a single negedge monitor.
module tb_pio_poll_scheduler;
  import pio_poll_pkg::*;

`ifdef PIO_POLL_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   m_chipselect;
  logic [1:0]   m_address;
  logic [127:0] m_readdata;
  logic [1:0]   s_address;
  logic         s_read;
  logic         s_write;
  logic [31:0]  s_writedata;
  logic [31:0]  s_readdata;
  logic         irq;
  logic [3:0]   pd [4];

  always #5 clk = ~clk;

  // Upper bits carry junk so the PORT_W slice is exercised.
  always_comb begin
    for (int i = 0; i < 4; i++) m_readdata[32*i +: 32] = {28'hABCDEF0, pd[i]};
  end

  pio_poll_scheduler #(
    .NUM_PORTS (4),
    .PORT_W    (4),
    .POLL_DIV  (16),
    .DEB_CNT   (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .m_chipselect (m_chipselect),
    .m_address    (m_address),
    .m_readdata   (m_readdata),
    .s_address    (s_address),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .irq          (irq)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] act;
    logic [31:0] exp;
  } probe_t;

  rd_exp_t    rd_q[$];
  logic [3:0] cs_q[$];
  probe_t     pr_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         cs0_cnt = 0;
  logic       rd_flag = 1'b0;
  logic       cs_mon_en = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_flag <= s_read;
    if (m_chipselect[0] === 1'b1) cs0_cnt <= cs0_cnt + 1;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rd_exp_t    r;
    probe_t     p;
    logic [3:0] c;
    if (rd_flag) begin
      if (rd_q.size() == 0) cmp("rd_unexpected", 32'(rd_q.size()), 32'd1);
      else begin
        r = rd_q.pop_front();
        cmp(r.name, s_readdata, r.exp);
      end
    end
    if (cs_mon_en && (m_chipselect != 4'b0000)) begin
      if (cs_q.size() == 0) cmp("cs_unexpected", {28'b0, m_chipselect}, 32'd0);
      else begin
        c = cs_q.pop_front();
        cmp("chipselect", {28'b0, m_chipselect}, {28'b0, c});
      end
    end
    while (pr_q.size() != 0) begin
      p = pr_q.pop_front();
      case (p.sel)
        1:       cmp(p.name, {28'b0, m_chipselect}, p.exp);
        2:       cmp(p.name, {31'b0, irq}, p.exp);
        3:       cmp(p.name, s_readdata, p.exp);
        default: cmp(p.name, p.act, p.exp);
      endcase
    end
  end

  task automatic probe(input string n, input int s, input logic [31:0] a, input logic [31:0] e);
    pr_q.push_back('{name: n, sel: s, act: a, exp: e});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    s_address   = a;
    s_writedata = d;
    s_write     = 1'b1;
    @(posedge clk);
    #1;
    s_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, input logic [31:0] e, input string n);
    s_address = a;
    s_read    = 1'b1;
    rd_q.push_back('{name: n, exp: e});
    @(posedge clk);
    #1;
    s_read = 1'b0;
  endtask

  task automatic push_round();
    cs_q.push_back(4'b0001);
    cs_q.push_back(4'b0010);
    cs_q.push_back(4'b0100);
    cs_q.push_back(4'b1000);
  endtask

  task automatic force_round();
    push_round();
    cpu_write(AddrCtrl, 32'h2);
    step(10);
  endtask

  task automatic wait_cs0(output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_chipselect[0] === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t1, t2, snap;
    reset_n     = 1'b0;
    s_read      = 1'b0;
    s_write     = 1'b0;
    s_address   = 2'd0;
    s_writedata = 32'h0;
    for (int i = 0; i < 4; i++) pd[i] = 4'h0;
    step(3);
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    cs_mon_en = 1'b1;

    probe("rst_cs", 1, 32'h0, 32'h0);
    probe("rst_irq", 2, 32'h0, 32'h0);
    probe("rst_rdata", 3, 32'h0, 32'h0);
    cpu_read(AddrState, 32'h0, "rst_state");
    cpu_read(AddrEdge, 32'h0, "rst_edge");
    cpu_read(AddrMask, 32'h0, "rst_mask");
    cpu_read(AddrCtrl, 32'h0, "rst_ctrl");

    // Forced round with EN=0: BUSY must read 1 for exactly 9 cycles.
    for (int i = 0; i < 4; i++) pd[i] = 4'h5;
    push_round();
    cpu_write(AddrCtrl, 32'h2);
    for (int k = 1; k <= 12; k++) cpu_read(AddrCtrl, (k <= 9) ? 32'h4 : 32'h0, "busy");
    step(2);

    for (int i = 0; i < 4; i++) pd[i] = 4'h0;
    repeat (3) force_round();

    // Port0 steps to A (accepted on 3rd round); port1 toggles and never settles.
    pd[0] = 4'hA;
    for (int r = 1; r <= 3; r++) begin
      pd[1] = (r == 2) ? 4'hC : 4'h3;
      force_round();
      cpu_read(AddrState, (r == 3) ? 32'h000A : 32'h0, "state_deb");
      cpu_read(AddrEdge, (r == 3) ? 32'h000A : 32'h0, "edge_deb");
    end

    cpu_write(AddrMask, 32'h000F);
    probe("irq_mask_lat", 2, 32'h0, 32'h0);
    step(1);
    probe("irq_mask", 2, 32'h0, {31'b0, IrqEn});
    cpu_read(AddrMask, IrqEn ? 32'h000F : 32'h0, "mask_rd");
    cpu_write(AddrEdge, 32'h000F);
    probe("irq_w1c_lat", 2, 32'h0, {31'b0, IrqEn});
    step(1);
    probe("irq_w1c", 2, 32'h0, 32'h0);
    cpu_read(AddrEdge, 32'h0, "edge_w1c");

    // Port0 A->5; the W1C lands on the UPD cycle of the accepting round.
    pd[1] = 4'h0;
    pd[0] = 4'h5;
    force_round();
    force_round();
    push_round();
    cpu_write(AddrCtrl, 32'h2);
    step(8);
    cpu_write(AddrEdge, 32'h000F);
    step(2);
    cpu_read(AddrEdge, 32'h000F, "edge_w1c_set");
    cpu_read(AddrState, 32'h0005, "state_b");
    probe("irq_w1c_set", 2, 32'h0, {31'b0, IrqEn});

    // Divider: ticks every 16 cycles; a mid-round FORCE adds exactly one round.
    cs_mon_en = 1'b0;
    cpu_write(AddrCtrl, 32'h1);
    wait_cs0(t1);
    @(negedge clk);
    wait_cs0(t2);
    probe("tick_period", 0, 32'(t2 - t1), 32'd16);
    snap = cs0_cnt;
    step(3);
    cpu_write(AddrCtrl, 32'h3);
    repeat (44) @(posedge clk);
    @(negedge clk);
    probe("extra_round", 0, 32'(cs0_cnt - snap), 32'd4);
    step(1);
    cpu_write(AddrCtrl, 32'h0);
    step(20);

    // Reset while port2 is selected.
    cpu_read(AddrState, 32'h0005, "state_pre_rst");
    for (int i = 0; i < 4; i++) pd[i] = 4'hF;
    cpu_write(AddrCtrl, 32'h2);
    step(4);
    probe("cs_port2", 1, 32'h0, 32'h4);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    probe("rst_async_cs", 1, 32'h0, 32'h0);
    probe("rst_async_irq", 2, 32'h0, 32'h0);
    probe("rst_async_rdata", 3, 32'h0, 32'h0);
    step(2);
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    cs_mon_en = 1'b1;
    cpu_read(AddrState, 32'h0, "post_rst_state");
    cpu_read(AddrEdge, 32'h0, "post_rst_edge");
    cpu_read(AddrMask, 32'h0, "post_rst_mask");
    cpu_read(AddrCtrl, 32'h0, "post_rst_ctrl");
    step(15);

    probe("rd_q_drained", 0, 32'(rd_q.size()), 32'd0);
    probe("cs_q_drained", 0, 32'(cs_q.size()), 32'd0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pio_poll_scheduler.md
PIO_POLL_SCHEDULER -- requirements
Module: pio_poll_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of polled PIO input slaves (1..4).
REQ-002 SHALL have parameter PORT_W, default 4, valid data bits per PIO port (1..8).
REQ-003 SHALL have parameter POLL_DIV, default 50000, clk cycles between poll rounds (>=16).
REQ-004 SHALL have parameter DEB_CNT, default 3, consecutive identical samples required to accept a new value (1..15).
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port m_chipselect  output  NUM_PORTS  one-hot PIO slave select.
REQ-008 SHALL have port m_address  output  2  PIO register address, always 0.
REQ-009 SHALL have port m_readdata  input  32*NUM_PORTS  concatenated PIO readdata; port i occupies bits [32i+31:32i].
REQ-010 SHALL have port s_address  input  2  CPU slave register select.
REQ-011 SHALL have port s_read  input  1  CPU read strobe.
REQ-012 SHALL have port s_write  input  1  CPU write strobe.
REQ-013 SHALL have port s_writedata  input  32  CPU write data.
REQ-014 SHALL have port s_readdata  output  32  CPU read data, registered.
REQ-015 SHALL have port irq  output  1  level interrupt.

Function
REQ-016 Slave map SHALL be: 0 STATE (RO, packed debounced values, port i at bits [i*PORT_W +: PORT_W]); 1 EDGE (W1C); 2 MASK (RW); 3 CTRL (bit0 EN RW, bit1 FORCE write-only self-clearing, bit2 BUSY RO).
REQ-017 s_readdata SHALL update one cycle after s_read with zero-extended register value; unused bits SHALL read 0.
REQ-018 Divider SHALL count 0..POLL_DIV-1 while EN=1, wrap to 0, and emit a tick on the wrap cycle; EN=0 SHALL hold the counter at 0.
REQ-019 A tick or FORCE arriving while BUSY SHALL set a single pending flag; multiple pending requests SHALL collapse into one round.
REQ-020 FSM states SHALL be IDLE, SEL, CAP, UPD.
REQ-021 IDLE->SEL on tick, FORCE or pending (pending cleared), index i=0; FORCE SHALL start a round even when EN=0.
REQ-022 SEL SHALL assert m_chipselect[i] for exactly one cycle; CAP SHALL latch m_readdata port i bits [PORT_W-1:0] (one-cycle PIO read latency).
REQ-023 CAP SHALL go to SEL with i+1 if i<NUM_PORTS-1, else to UPD; UPD SHALL last one cycle and return to IDLE.
REQ-024 A round SHALL take exactly 2*NUM_PORTS+1 cycles after leaving IDLE; BUSY SHALL be 1 in every non-IDLE state.
REQ-025 Per port in UPD: sample==previous sample increments stable count, saturating at DEB_CNT; otherwise count reloads to 1.
REQ-026 When count>=DEB_CNT and sample!=STATE port, STATE port SHALL take sample and the EDGE bits for changed bits SHALL be set.
REQ-027 EDGE bit set in UPD and W1C on the same cycle SHALL remain set.
REQ-028 m_chipselect SHALL be 0 outside SEL.

Reset
REQ-029 reset_n low SHALL asynchronously clear STATE, EDGE, MASK, CTRL, samples, counts, pending flag, divider, s_readdata, m_chipselect and irq, with the FSM in IDLE.
REQ-030 Reset mid-round SHALL abort the round; no partial STATE update SHALL survive.

Configuration
REQ-031 With macro PIO_POLL_IRQ_EN defined, irq SHALL be registered |(EDGE & MASK), asserted one cycle after the causing EDGE/MASK change.
REQ-032 Without PIO_POLL_IRQ_EN, irq SHALL be constant 0, MASK SHALL read 0, and MASK writes SHALL be ignored.

Structure
REQ-033 A shared package pio_poll_pkg SHALL hold the FSM state enum, register address constants and CTRL bit positions.
REQ-034 Per-port debounce (sample, count, compare) SHALL be a sub-module pio_poll_debounce, instantiated NUM_PORTS times.

Verification
REQ-035 EN=0, FORCE write, all ports 4'h5 -> chipselects 0001,0010,0100,1000 one cycle each, BUSY 9 cycles.
REQ-036 DEB_CNT=3, port0 steps 0->4'hA, three forced rounds -> STATE[3:0]=A after round 3 only, EDGE[3:0]=4'hA.
REQ-037 Port1 toggles 3<->C every round -> STATE port1 unchanged, EDGE port1 bits stay 0.
REQ-038 MASK=16'h000F, port0 edge -> irq=1; write EDGE=16'h000F -> irq=0 next cycle; W1C coinciding with new set -> bit stays 1.
REQ-039 POLL_DIV=16, EN=1, FORCE issued mid-round -> exactly one extra round follows; ticks every 16 cycles.
REQ-040 reset_n low during SEL of port2 -> all outputs 0 immediately, STATE=0 after release.
